// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared owner encoding, memory-side idle levels and the
// registered command type for the DataMemory arbiter.
package dmem_arb_pkg;

    localparam int unsigned CMD_AW = 32;
    localparam int unsigned CMD_DW = 32;

    typedef enum logic {
        OWNER_CPU = 1'b0,
        OWNER_DBG = 1'b1
    } owner_e;

    // DataMemory strobes are active-low; these are their parked levels.
    localparam logic RD_IDLE = 1'b1;
    localparam logic WR_IDLE = 1'b1;

    typedef struct packed {
        logic              we;
        logic [CMD_AW-1:0] addr;
        logic [CMD_DW-1:0] wdata;
        owner_e            owner;
    } dmem_cmd_t;

    function automatic logic addr_aligned(input logic [1:0] lsb);
        return lsb == 2'b00;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr.sv
// rr_arbiter2: two-way round-robin pick with a last-grant pointer.
// A lone requester always wins; on contention the requester that was not
// granted last wins. Pointer resets to OWNER_DBG so OWNER_CPU wins first.
module rr_arbiter2
    import dmem_arb_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o,
    output owner_e     winner_o
);

    owner_e last_q;

    // Combinational winner selection from the live requests and the pointer.
    always_comb begin
        winner_o = OWNER_CPU;
        if (req_i == 2'b11) begin
            winner_o = (last_q == OWNER_DBG) ? OWNER_CPU : OWNER_DBG;
        end else if (req_i[1]) begin
            winner_o = OWNER_DBG;
        end
    end

    assign gnt_o[0] = req_i[0] & (winner_o == OWNER_CPU);
    assign gnt_o[1] = req_i[1] & (winner_o == OWNER_DBG);

    // Remember who was granted whenever a grant is issued.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_q <= OWNER_DBG;
        end else if (req_i != 2'b00) begin
            last_q <= winner_o;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester arbiter/sequencer in front of the single-port
// DataMemory. Stage A grants and registers one command per cycle, stage X
// drives DAddr/DataIn/RD/WR for one cycle, the response (rdata plus the
// owner's rvalid strobe) follows one cycle later.
// Optional build macro DMEM_ARB_ALIGN_CHECK_EN: misaligned commands are not
// issued to memory and are answered with err=1.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) (
    input  logic          CLK,
    input  logic          Reset,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] rdata,
    output logic          err,
    output logic [AW-1:0] DAddr,
    output logic [DW-1:0] DataIn,
    output logic          RD,
    output logic          WR,
    input  logic [DW-1:0] DataOut
);

    logic [1:0] req;
    logic [1:0] gnt;
    owner_e     winner;
    dmem_cmd_t  cmd_d;
    dmem_cmd_t  cmd_q;
    logic       xvalid_q;
    logic       issue;
    logic       bad;
    logic [1:0] rvalid_q;
    logic [DW-1:0] rdata_q;
    logic       err_q;

    // No grant may be reported while reset is held.
    assign req = {m1_req, m0_req} & {2{~Reset}};

    rr_arbiter2 u_rr (
        .clk_i    (CLK),
        .rst_i    (Reset),
        .req_i    (req),
        .gnt_o    (gnt),
        .winner_o (winner)
    );

    assign m0_gnt = gnt[0];
    assign m1_gnt = gnt[1];

    // Select the winning requester's command fields.
    always_comb begin
        cmd_d = '0;
        if (winner == OWNER_DBG) begin
            cmd_d.we    = m1_we;
            cmd_d.addr  = m1_addr;
            cmd_d.wdata = m1_wdata;
        end else begin
            cmd_d.we    = m0_we;
            cmd_d.addr  = m0_addr;
            cmd_d.wdata = m0_wdata;
        end
        cmd_d.owner = winner;
    end

    // Stage A -> X: capture the granted command; idle cycles park the
    // command register at zero so DAddr/DataIn read 0 when nothing is issued.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            cmd_q    <= '0;
            xvalid_q <= 1'b0;
        end else begin
            xvalid_q <= |req;
            cmd_q    <= (|req) ? cmd_d : '0;
        end
    end

`ifdef DMEM_ARB_ALIGN_CHECK_EN
    assign issue = xvalid_q & addr_aligned(cmd_q.addr[1:0]);
    assign bad   = xvalid_q & ~addr_aligned(cmd_q.addr[1:0]);
`else
    assign issue = xvalid_q;
    assign bad   = 1'b0;
`endif

    assign DAddr  = cmd_q.addr;
    assign DataIn = cmd_q.wdata;
    assign RD     = (issue & ~cmd_q.we) ? ~RD_IDLE : RD_IDLE;
    assign WR     = (issue &  cmd_q.we) ? ~WR_IDLE : WR_IDLE;

    // Stage X -> response: strobe the owner, latch read data on issued reads.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            rvalid_q <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            rvalid_q[0] <= xvalid_q & (cmd_q.owner == OWNER_CPU);
            rvalid_q[1] <= xvalid_q & (cmd_q.owner == OWNER_DBG);
            err_q       <= bad;
            if (issue & ~cmd_q.we) begin
                rdata_q <= DataOut;
            end
        end
    end

    assign m0_rvalid = rvalid_q[0];
    assign m1_rvalid = rvalid_q[1];
    assign rdata     = rdata_q;
    assign err       = err_q;

endmodule
